maple_regbank: RTL
==================

// Module: maple_regbank
// PURPOSE
//  Register bank behind the SPI register-access front end. It decodes the
//  7-bit register number and read/write strobes into ID/status/control
//  registers and two byte FIFOs (TX toward the Maple bus engine, RX from it).
//  RX pops are committed only once the byte has actually been shifted out.
// PARAMETERS
//  FIFO_DEPTH_LOG2  5      log2 of TX and RX FIFO depth (32 entries); range 2..7
//  ID_VALUE         8'h4D  constant returned by register 0x00
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous, active-high reset
//  ss             in   1  SPI slave select, clk-synchronous; high = no transaction
//  regnum         in   7  register number from the SPI front end
//  regdata_write  in   8  write data, valid while write=1
//  write          in   1  one-cycle write strobe
//  read           in   1  one-cycle read strobe; sample regdata_read this cycle
//  regdata_read   out  8  combinational read data for current regnum/state
//  tx_data        out  8  TX FIFO head
//  tx_valid       out  1  TX FIFO not empty
//  tx_ready       in   1  engine pops TX head when tx_valid&tx_ready
//  rx_data        in   8  byte from engine
//  rx_valid       in   1  push rx_data into RX FIFO
//  start          out  1  one-cycle start pulse to engine
//  busy           in   1  engine busy, reported in STATUS
// BEHAVIOUR
//  Register map (unlisted: read 0x00, write ignored):
//   0x00 ID RO = ID_VALUE
//   0x01 STATUS RO {rx_ovf,tx_ovf,busy,tx_full,tx_empty,rx_full,rx_empty,loopback}
//   0x02 CTRL W: b0 start, b1 rx_flush, b2 tx_flush, b3 loopback, b7 clear ovf
//        (b0,b1,b2,b7 self-clearing); R: {4'b0,loopback,3'b0}
//   0x03 TX_DATA W: push; R: 0x00
//   0x04 RX_DATA R: RX head (0x00 if empty), pop is deferred (see below)
//   0x05 RX_COUNT R; 0x06 TX_COUNT R (zero-extended to 8 bits)
//  Reset: regdata_read follows decode of empty state; tx_valid=0, start=0,
//   loopback=0, flags=0, both FIFOs empty, pop_pending=0.
//  Write latency: TX push visible on tx_valid next cycle; start asserted the
//   cycle after CTRL write with b0=1, for exactly one cycle.
//  Deferred RX pop: read of 0x04 with RX non-empty sets pop_pending. The next
//   read strobe (any regnum) commits the pop before its data is decoded, so
//   the presented head has advanced. ss sampled high clears pop_pending
//   without popping (last prefetched byte never shifted out, not lost).
//  Full/empty: TX push when full -> dropped, tx_ovf=1 sticky; RX push when
//   full -> dropped, rx_ovf=1 sticky. Push and pop in the same cycle: both
//   take effect, count unchanged; push on full plus pop is accepted.
//  Pointers wrap modulo 2**FIFO_DEPTH_LOG2; counts FIFO_DEPTH_LOG2+1 bits.
//  Flush beats a simultaneous push/pop on the same FIFO; flushing RX also
//   clears pop_pending. CTRL b7 clears both ovf flags; a same-cycle new
//   overflow wins (flag stays 1).
//  rst mid-transaction: all state returns to reset values next edge.
// CONFIGURATION
//  MAPLE_REGBANK_LOOPBACK_EN defined: CTRL b3 is writable; with loopback=1
//   tx_valid to engine is forced 0 and the TX head is moved into the RX FIFO
//   (one byte per cycle when TX non-empty and RX not full), rx_valid ignored.
//  Undefined: b3 ignored, loopback reads 0, no loopback datapath built.
// TESTING
//  1 After reset read 0x00/0x01 -> 0x4D / 0x0A (tx_empty,rx_empty set).
//  2 Write 0x11,0x22,0x33 to 0x03 -> TX_COUNT=3; tx_ready=1 -> tx_data
//    0x11,0x22,0x33 in order, then tx_valid=0.
//  3 Push 0xA5,0x5A via rx_valid; reads of 0x04,0x04 then ss high ->
//    returned 0xA5,0x5A; RX_COUNT=1 (0x5A not popped).
//  4 Push 33 bytes into RX (depth 32) -> RX_COUNT=32, STATUS b7=1; CTRL
//    write 0x80 -> b7=0; CTRL write 0x02 -> RX_COUNT=0.
//  5 CTRL write 0x01 -> start high exactly one cycle; rst asserted with
//    pop_pending and 4 TX bytes -> TX_COUNT=0, pop_pending=0, start=0.
//  6 LOOPBACK_EN: CTRL 0x08, write 0x3C to 0x03 -> tx_valid stays 0,
//    RX_DATA reads 0x3C.

Source files
------------

// File: rtl/maple_regbank.sv
// maple_regbank: ID/status/control registers plus TX/RX byte FIFOs behind the SPI register front end.
// Optional build macro MAPLE_REGBANK_LOOPBACK_EN adds the CTRL b3 loopback path (TX head fed into RX).
module maple_regbank #(
    parameter int         FIFO_DEPTH_LOG2 = 5,
    parameter logic [7:0] ID_VALUE        = 8'h4D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic [6:0] regnum,
    input  logic [7:0] regdata_write,
    input  logic       write,
    input  logic       read,
    output logic [7:0] regdata_read,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       start,
    input  logic       busy
);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [AW-1:0] P1    = AW'(1);
    localparam logic [CW-1:0] C1    = CW'(1);
    localparam logic [CW-1:0] CFULL = CW'(DEPTH);

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic          start_q, start_d, pend_q, pend_d;
    logic          loopback;

    logic          wr_ctrl, wr_tx, commit;
    logic          flush_tx, flush_rx, clr_ovf;
    logic          tx_empty, tx_full, rx_full;
    logic          tx_pop, tx_push_ok, rx_push, rx_push_ok;
    logic [7:0]    rx_push_data;
    logic [AW-1:0] rx_rd_eff;
    logic [CW-1:0] rx_cnt_eff;
    logic          rx_empty_eff, rx_full_eff;

    assign wr_ctrl  = write && (regnum == 7'h02);
    assign wr_tx    = write && (regnum == 7'h03);
    assign flush_rx = wr_ctrl && regdata_write[1];
    assign flush_tx = wr_ctrl && regdata_write[2];
    assign clr_ovf  = wr_ctrl && regdata_write[7];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CFULL);
    assign rx_full  = (rx_cnt_q == CFULL);

    // A pending RX pop lands on the next read strobe, so that read already sees the advanced head.
    assign commit       = read && pend_q && !ss;
    assign rx_rd_eff    = commit ? rx_rd_q + P1 : rx_rd_q;
    assign rx_cnt_eff   = commit ? rx_cnt_q - C1 : rx_cnt_q;
    assign rx_empty_eff = (rx_cnt_eff == '0);
    assign rx_full_eff  = (rx_cnt_eff == CFULL);

    assign tx_data = tx_mem[tx_rd_q];

`ifdef MAPLE_REGBANK_LOOPBACK_EN
    logic loopback_q, loopback_d, lb_move;

    assign loopback     = loopback_q;
    assign loopback_d   = wr_ctrl ? regdata_write[3] : loopback_q;
    assign lb_move      = loopback_q && !tx_empty && !rx_full;
    assign tx_valid     = !loopback_q && !tx_empty;
    assign tx_pop       = loopback_q ? lb_move : (tx_valid && tx_ready);
    assign rx_push      = loopback_q ? lb_move : rx_valid;
    assign rx_push_data = loopback_q ? tx_mem[tx_rd_q] : rx_data;

    always_ff @(posedge clk) begin
        if (rst) loopback_q <= 1'b0;
        else     loopback_q <= loopback_d;
    end
`else
    assign loopback     = 1'b0;
    assign tx_valid     = !tx_empty;
    assign tx_pop       = tx_valid && tx_ready;
    assign rx_push      = rx_valid;
    assign rx_push_data = rx_data;
`endif

    assign tx_push_ok = wr_tx && (!tx_full || tx_pop);
    assign rx_push_ok = rx_push && (!rx_full || commit);

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_push_ok) tx_wr_d = tx_wr_q + P1;
        if (tx_pop)     tx_rd_d = tx_rd_q + P1;
        if (tx_push_ok && !tx_pop)      tx_cnt_d = tx_cnt_q + C1;
        else if (!tx_push_ok && tx_pop) tx_cnt_d = tx_cnt_q - C1;
        if (rx_push_ok) rx_wr_d = rx_wr_q + P1;
        rx_rd_d = rx_rd_eff;
        if (rx_push_ok && !commit)      rx_cnt_d = rx_cnt_q + C1;
        else if (!rx_push_ok && commit) rx_cnt_d = rx_cnt_q - C1;
        if (flush_tx) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end
        if (flush_rx) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end
        // A fresh overflow in the same cycle as a clear keeps the flag set.
        tx_ovf_d = (wr_tx && tx_full && !tx_pop) || (tx_ovf_q && !clr_ovf);
        rx_ovf_d = (rx_push && rx_full && !commit) || (rx_ovf_q && !clr_ovf);
        start_d  = wr_ctrl && regdata_write[0];
        pend_d   = pend_q;
        if (ss || flush_rx) pend_d = 1'b0;
        else if (read)      pend_d = (regnum == 7'h04) && !rx_empty_eff;
    end

    always_comb begin
        regdata_read = 8'h00;
        case (regnum)
            7'h00: regdata_read = ID_VALUE;
            7'h01: regdata_read = {rx_ovf_q, tx_ovf_q, busy, tx_full, tx_empty,
                                   rx_full_eff, rx_empty_eff, loopback};
            7'h02: regdata_read = {4'b0000, loopback, 3'b000};
            7'h04: regdata_read = rx_empty_eff ? 8'h00 : rx_mem[rx_rd_eff];
            7'h05: regdata_read = 8'(rx_cnt_eff);
            7'h06: regdata_read = 8'(tx_cnt_q);
            default: regdata_read = 8'h00;
        endcase
    end

    assign start = start_q;

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wr_q] <= regdata_write;
        if (rx_push_ok) rx_mem[rx_wr_q] <= rx_push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            start_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            start_q  <= start_d;
            pend_q   <= pend_d;
        end
    end
endmodule
